// File: rtl/ins_loader_pkg.sv
// Shared definitions for the instruction loader and the instruction memory it fills.
package ins_loader_pkg;

    localparam int RAM_SIZE      = 256;
    localparam int RAM_SIZE_BIT  = 8;
    localparam int RAM_INST_SIZE = 32;

    localparam int         WORD_W        = 32;
    localparam logic [1:0] LAST_BYTE_IDX = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } loader_state_t;

endpackage

// File: rtl/ins_loader_word_assembler.sv
// Collects four bytes little-endian into one word and tracks the byte position.
module word_assembler
    import ins_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [7:0]        byte_data,
    output logic [1:0]        byte_cnt,
    output logic              last_byte,
    output logic [WORD_W-1:0] word_next
);

    logic [WORD_W-1:0] word_r;
    logic [1:0]        byte_cnt_r;
    logic [WORD_W-1:0] word_next_s;

    // Merge the incoming byte into the lane selected by the current position.
    always_comb begin
        word_next_s = word_r;
        case (byte_cnt_r)
            2'd0:    word_next_s[7:0]   = byte_data;
            2'd1:    word_next_s[15:8]  = byte_data;
            2'd2:    word_next_s[23:16] = byte_data;
            2'd3:    word_next_s[31:24] = byte_data;
            default: word_next_s        = word_r;
        endcase
    end

    // Position and partial-word registers; a clear discards any partial word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_r     <= {WORD_W{1'b0}};
            byte_cnt_r <= 2'd0;
        end else if (clear) begin
            word_r     <= {WORD_W{1'b0}};
            byte_cnt_r <= 2'd0;
        end else if (load) begin
            byte_cnt_r <= byte_cnt_r + 2'd1;
            word_r     <= (byte_cnt_r == LAST_BYTE_IDX) ? {WORD_W{1'b0}} : word_next_s;
        end
    end

    assign byte_cnt  = byte_cnt_r;
    assign last_byte = (byte_cnt_r == LAST_BYTE_IDX);
    assign word_next = word_next_s;

endmodule

// File: rtl/ins_loader.sv
// Byte-stream instruction loader: assembles words and writes them to instruction
// memory while holding the CPU in reset, with an inter-byte timeout.
module ins_loader
    import ins_loader_pkg::*;
#(
    parameter int RAM_SIZE      = ins_loader_pkg::RAM_SIZE,
    parameter int RAM_SIZE_BIT  = ins_loader_pkg::RAM_SIZE_BIT,
    parameter int RAM_INST_SIZE = ins_loader_pkg::RAM_INST_SIZE,
    parameter int TIMEOUT       = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic [31:0] Address,
    output logic [31:0] Write_data,
    output logic        MemWrite,
    output logic        busy,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    // Session length is clamped to the memory so no out-of-range address is written.
    localparam int INST_WORDS = (RAM_INST_SIZE > RAM_SIZE) ? RAM_SIZE :
                                ((RAM_INST_SIZE < 1) ? 1 : RAM_INST_SIZE);
    localparam logic [RAM_SIZE_BIT-1:0] LAST_WORD = RAM_SIZE_BIT'(INST_WORDS - 1);
    localparam int IDLE_W   = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT);
    localparam int ADDR_PAD = 32 - RAM_SIZE_BIT - 2;

    loader_state_t          state_r;
    logic [RAM_SIZE_BIT-1:0] word_cnt_r;
    logic [IDLE_W-1:0]       idle_cnt_r;
    logic                    byte_ready_r;
    logic [31:0]             address_r;
    logic [31:0]             write_data_r;
    logic                    mem_write_r;
    logic                    busy_r;
    logic                    cpu_hold_r;
    logic                    done_r;
    logic                    error_r;

    logic                    accept_s;
    logic                    start_ok_s;
    logic                    timeout_s;
    logic                    asm_clear_s;
    logic [IDLE_W-1:0]       idle_inc_s;
    logic [RAM_SIZE_BIT-1:0] word_cnt_inc_s;
    logic [31:0]             addr_cur_s;
    logic [31:0]             addr_inc_s;
    logic [1:0]              byte_cnt_s;
    logic                    last_byte_s;
    logic [31:0]             word_next_s;

    word_assembler u_word_assembler (
        .clk       (clk),
        .reset     (reset),
        .clear     (asm_clear_s),
        .load      (accept_s),
        .byte_data (byte_data),
        .byte_cnt  (byte_cnt_s),
        .last_byte (last_byte_s),
        .word_next (word_next_s)
    );

    // Handshake, start qualification, timeout detection and address arithmetic.
    always_comb begin
        accept_s       = byte_ready_r & byte_valid;
        idle_inc_s     = idle_cnt_r + IDLE_W'(1);
        word_cnt_inc_s = word_cnt_r + RAM_SIZE_BIT'(1);
        addr_cur_s     = {{ADDR_PAD{1'b0}}, word_cnt_r, 2'b00};
        addr_inc_s     = {{ADDR_PAD{1'b0}}, word_cnt_inc_s, 2'b00};
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: start_ok_s = start;
            default:                    start_ok_s = 1'b0;
        endcase
        if ((state_r == ST_RECV) && !accept_s && (byte_cnt_s != 2'd0)) begin
            timeout_s = (idle_inc_s == IDLE_LIMIT);
        end else begin
            timeout_s = 1'b0;
        end
        asm_clear_s = start_ok_s | timeout_s;
    end

    // Loader FSM with counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            word_cnt_r   <= {RAM_SIZE_BIT{1'b0}};
            idle_cnt_r   <= {IDLE_W{1'b0}};
            byte_ready_r <= 1'b0;
            address_r    <= 32'd0;
            write_data_r <= 32'd0;
            mem_write_r  <= 1'b0;
            busy_r       <= 1'b0;
            cpu_hold_r   <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    mem_write_r <= 1'b0;
                    if (start_ok_s) begin
                        state_r      <= ST_RECV;
                        word_cnt_r   <= {RAM_SIZE_BIT{1'b0}};
                        idle_cnt_r   <= {IDLE_W{1'b0}};
                        address_r    <= 32'd0;
                        byte_ready_r <= 1'b1;
                        busy_r       <= 1'b1;
                        cpu_hold_r   <= 1'b1;
                        done_r       <= 1'b0;
                        error_r      <= 1'b0;
                    end
                end
                ST_RECV: begin
                    mem_write_r <= 1'b0;
                    if (accept_s) begin
                        idle_cnt_r <= {IDLE_W{1'b0}};
                        if (last_byte_s) begin
                            state_r      <= ST_WRITE;
                            byte_ready_r <= 1'b0;
                            mem_write_r  <= 1'b1;
                            write_data_r <= word_next_s;
                            address_r    <= addr_cur_s;
                        end
                    end else if (timeout_s) begin
                        // Partial word is dropped by the assembler clear; no write issued.
                        state_r      <= ST_ERROR;
                        idle_cnt_r   <= idle_inc_s;
                        byte_ready_r <= 1'b0;
                        busy_r       <= 1'b0;
                        cpu_hold_r   <= 1'b0;
                        error_r      <= 1'b1;
                    end else if (byte_cnt_s != 2'd0) begin
                        idle_cnt_r <= idle_inc_s;
                    end
                end
                ST_WRITE: begin
                    mem_write_r <= 1'b0;
                    word_cnt_r  <= word_cnt_inc_s;
                    address_r   <= addr_inc_s;
                    if (word_cnt_r == LAST_WORD) begin
                        state_r      <= ST_DONE;
                        byte_ready_r <= 1'b0;
                        busy_r       <= 1'b0;
                        cpu_hold_r   <= 1'b0;
                        done_r       <= 1'b1;
                    end else begin
                        state_r      <= ST_RECV;
                        byte_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    byte_ready_r <= 1'b0;
                    mem_write_r  <= 1'b0;
                    busy_r       <= 1'b0;
                    cpu_hold_r   <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready = byte_ready_r;
    assign Address    = address_r;
    assign Write_data = write_data_r;
    assign MemWrite   = mem_write_r;
    assign busy       = busy_r;
    assign cpu_hold   = cpu_hold_r;
    assign done       = done_r;
    assign error      = error_r;

endmodule

// File: tb/tb_ins_loader.sv
// Scoreboard bench for ins_loader: a 2-word/short-timeout instance and a default instance.
module tb_ins_loader;

    typedef logic [63:0] wr_t;

    logic clk = 1'b0;
    logic reset, reset_b, start, byte_valid;
    logic [7:0] byte_data;

    logic        byte_ready_a, MemWrite_a, busy_a, cpu_hold_a, done_a, error_a;
    logic [31:0] Address_a, Write_data_a;
    logic        byte_ready_b, MemWrite_b, busy_b, cpu_hold_b, done_b, error_b;
    logic [31:0] Address_b, Write_data_b;

    wr_t         exp_a[$];
    wr_t         exp_b[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          wr_cnt_b = 0;
    logic [31:0] last_addr_b = 32'd0;

    always #5 clk = ~clk;

    ins_loader #(.RAM_INST_SIZE(2), .TIMEOUT(10)) dut_a (
        .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready_a), .Address(Address_a),
        .Write_data(Write_data_a), .MemWrite(MemWrite_a), .busy(busy_a),
        .cpu_hold(cpu_hold_a), .done(done_a), .error(error_a)
    );

    ins_loader dut_b (
        .clk(clk), .reset(reset_b), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready_b), .Address(Address_b),
        .Write_data(Write_data_b), .MemWrite(MemWrite_b), .busy(busy_b),
        .cpu_hold(cpu_hold_b), .done(done_b), .error(error_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    endtask

    // Monitor for the short instance: every write must match the next expected word.
    always @(negedge clk) begin
        wr_t e;
        if (MemWrite_a === 1'b1) begin
            chk("ready_low_in_write_a", {31'd0, byte_ready_a}, 32'd0);
            if (exp_a.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write_a: Address 0x%08h data 0x%08h, expected no write",
                         Address_a, Write_data_a);
            end else begin
                e = exp_a.pop_front();
                chk("addr_a", Address_a, e[63:32]);
                chk("data_a", Write_data_a, e[31:0]);
            end
        end
    end

    // Monitor for the default instance.
    always @(negedge clk) begin
        wr_t e;
        if (MemWrite_b === 1'b1) begin
            wr_cnt_b++;
            last_addr_b = Address_b;
            if (exp_b.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write_b: Address 0x%08h data 0x%08h, expected no write",
                         Address_b, Write_data_b);
            end else begin
                e = exp_b.pop_front();
                chk("addr_b", Address_b, e[63:32]);
                chk("data_b", Write_data_b, e[31:0]);
            end
        end
    end

    // All tasks are entered and left on a falling edge.
    task automatic send_byte(input logic [7:0] d, input bit use_b);
        int n = 0;
        byte_valid = 1'b1;
        byte_data  = d;
        while (((use_b ? byte_ready_b : byte_ready_a) !== 1'b1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_total++;
            $display("FAIL handshake_timeout: byte_ready low for %0d cycles, expected acceptance", n);
        end else begin
            @(negedge clk);
        end
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Reference: word w of a session is bytes 4w..4w+3 little-endian, written at 4*w.
    task automatic run_session(input int nwords, input int gmin, input int gmax,
                               input bit use_b, input bit mid_start);
        logic [7:0] b [4];
        pulse_start();
        for (int w = 0; w < nwords; w++) begin
            for (int k = 0; k < 4; k++) b[k] = 8'($urandom);
            if (use_b) exp_b.push_back({32'(w * 4), b[3], b[2], b[1], b[0]});
            else       exp_a.push_back({32'(w * 4), b[3], b[2], b[1], b[0]});
            for (int k = 0; k < 4; k++) begin
                send_byte(b[k], use_b);
                if (mid_start && (k == 1 || k == 3)) pulse_start();
                repeat ($urandom_range(gmax, gmin)) @(negedge clk);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] fixed [8];
        fixed = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        reset = 1'b1; reset_b = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_byte_ready", {31'd0, byte_ready_a}, 32'd0);
        chk("rst_memwrite",   {31'd0, MemWrite_a}, 32'd0);
        chk("rst_busy_hold",  {30'd0, busy_a, cpu_hold_a}, 32'd0);
        chk("rst_done_error", {30'd0, done_a, error_a}, 32'd0);
        chk("rst_address",    Address_a, 32'd0);
        chk("rst_write_data", Write_data_a, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed two-word load, back-to-back bytes.
        exp_a.push_back({32'h0, 32'h12345678});
        exp_a.push_back({32'h4, 32'hDEADBEEF});
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            send_byte(fixed[i], 1'b0);
            if (i == 3) begin
                chk("latency_memwrite", {31'd0, MemWrite_a}, 32'd1);
                chk("cpu_hold_loading", {31'd0, cpu_hold_a}, 32'd1);
            end
        end
        @(negedge clk);
        chk("done_after_load", {31'd0, done_a}, 32'd1);
        chk("cpu_hold_released", {30'd0, cpu_hold_a, busy_a}, 32'd0);

        // Start in DONE restarts at address 0; byte_valid every other cycle.
        run_session(2, 1, 1, 1'b0, 1'b0);
        chk("done_toggle", {31'd0, done_a}, 32'd1);

        // Start pulses mid-word and during WRITE are ignored.
        run_session(2, 0, 2, 1'b0, 1'b1);
        chk("done_mid_start", {31'd0, done_a}, 32'd1);

        for (int s = 0; s < 4; s++) begin
            run_session(2, 0, 3, 1'b0, 1'b0);
            chk("done_random", {30'd0, done_a, error_a}, 32'd2);
        end

        // Timeout: two bytes then silence.
        pulse_start();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h5A, 1'b0);
        repeat (9) @(negedge clk);
        chk("no_error_before_timeout", {31'd0, error_a}, 32'd0);
        repeat (3) @(negedge clk);
        chk("error_after_timeout", {31'd0, error_a}, 32'd1);
        chk("ready_low_in_error", {31'd0, byte_ready_a}, 32'd0);
        chk("idle_in_error", {29'd0, busy_a, cpu_hold_a, done_a}, 32'd0);
        byte_valid = 1'b1; byte_data = 8'h33;
        repeat (6) @(negedge clk);
        byte_valid = 1'b0;
        chk("no_write_in_error", 32'(exp_a.size()), 32'd0);
        run_session(2, 0, 1, 1'b0, 1'b0);
        chk("recover_after_error", {30'd0, done_a, error_a}, 32'd2);

        // Reset after three bytes of word 1.
        exp_a.push_back({32'h0, 32'h44332211});
        pulse_start();
        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b0);
        send_byte(8'h55, 1'b0); send_byte(8'h66, 1'b0); send_byte(8'h77, 1'b0);
        reset = 1'b1;
        #1;
        chk("abort_address", Address_a, 32'd0);
        chk("abort_write_data", Write_data_a, 32'd0);
        chk("abort_flags", {26'd0, byte_ready_a, MemWrite_a, busy_a, cpu_hold_a, done_a, error_a}, 32'd0);
        @(negedge clk);
        byte_valid = 1'b1; byte_data = 8'h88;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        byte_valid = 1'b0;
        chk("abort_no_write", 32'(exp_a.size()), 32'd0);
        chk("abort_idle", {31'd0, busy_a}, 32'd0);

        // Default instance: full 32-word session.
        reset = 1'b1;
        reset_b = 1'b0;
        @(negedge clk);
        run_session(32, 0, 1, 1'b1, 1'b0);
        chk("b_write_count", 32'(wr_cnt_b), 32'd32);
        chk("b_last_address", last_addr_b, 32'h7C);
        chk("b_done", {31'd0, done_b}, 32'd1);
        chk("b_idle", {29'd0, busy_b, cpu_hold_b, error_b}, 32'd0);
        chk("b_queue_empty", 32'(exp_b.size()), 32'd0);
        chk("a_queue_empty", 32'(exp_a.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
